// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared definitions for the LED clock time-set path: the 2-bit
//             mode codes (also consumed by the LED mode processor) and the
//             increment state machine encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SECS  = 2'd1;
  localparam logic [1:0] MODE_MINS  = 2'd2;
  localparam logic [1:0] MODE_HOURS = 2'd3;

  typedef enum logic [1:0] {
    INC_IDLE    = 2'd0,
    INC_HOLD    = 2'd1,
    INC_REPEAT  = 2'd2,
    INC_LOCKOUT = 2'd3
  } inc_state_t;

  // Mode advance; the 3 -> 0 wrap comes from the natural 2-bit overflow.
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_controller_if
//  Purpose  : Bundles the raw button pads and the time-set outputs.
//  Signals  : mode_btn, inc_btn        raw pads (active-high, asynchronous)
//             mode[1:0], run_en        current mode / 1 Hz advance gate
//             inc_secs/mins/hours      one-cycle increment pulses
//             mode_chg                 one-cycle pulse per mode advance
//  Modports : master - drives the pads, observes the outputs
//             slave  - the controller
//  Revision : 1.0 - initial release
// ============================================================================
interface time_set_controller_if;
  logic       mode_btn;
  logic       inc_btn;
  logic [1:0] mode;
  logic       run_en;
  logic       inc_secs;
  logic       inc_mins;
  logic       inc_hours;
  logic       mode_chg;

  modport master (
    output mode_btn, inc_btn,
    input  mode, run_en, inc_secs, inc_mins, inc_hours, mode_chg
  );

  modport slave (
    input  mode_btn, inc_btn,
    output mode, run_en, inc_secs, inc_mins, inc_hours, mode_chg
  );
endinterface
`default_nettype wire

// File: rtl/time_set_controller_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Conditions one raw button: 2-flop synchroniser, then a debounce
//             counter that accepts a new level only after DEBOUNCE_CYCLES
//             consecutive synchronised samples differing from the current one.
//  Ports    : clk      in  system clock
//             reset_n  in  asynchronous active-low reset
//             btn_raw  in  raw pad level
//             level    out debounced level
//             rise     out one-cycle pulse, registered together with level
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        // Any agreeing sample restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This sample completes the run of differing samples; the counter
        // never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_controller
//  Purpose  : Time-set front end: debounces MODE/INC, steps the set mode
//             RUN -> SET_SECS -> SET_MINS -> SET_HOURS -> RUN and issues
//             single-cycle increment pulses with auto-repeat on long press.
//  Ports    : clk      in  system clock
//             reset_n  in  asynchronous active-low reset
//             bus      slave modport of time_set_controller_if
//                      (mode_btn, inc_btn in; mode, run_en, inc_secs,
//                       inc_mins, inc_hours, mode_chg out)
//  Revision : 1.0 - initial release
// ============================================================================
module time_set_controller
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 3,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  time_set_controller_if.slave bus
);

  // Only the press edge of MODE matters; its level is deliberately unused.
  logic w_mode_level_unused;
  logic w_mode_rise;
  logic w_inc_level;
  logic w_inc_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_mode_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (bus.mode_btn),
    .level   (w_mode_level_unused),
    .rise    (w_mode_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_inc_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (bus.inc_btn),
    .level   (w_inc_level),
    .rise    (w_inc_rise)
  );

  inc_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_secs, r_mins, r_hours, r_chg;
  logic             w_secs_nxt, w_mins_nxt, w_hours_nxt;
  logic             w_fire;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_cnt_inc;

  // The counter restarts at 1 on each pulse, so reaching the limit marks
  // exactly HOLD_CYCLES / REPEAT_CYCLES cycles since that pulse.
  assign w_limit   = (r_state == INC_HOLD) ? CNT_W'(HOLD_CYCLES) : CNT_W'(REPEAT_CYCLES);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INC_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_RUN;
      r_secs  <= 1'b0;
      r_mins  <= 1'b0;
      r_hours <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_secs  <= w_secs_nxt;
      r_mins  <= w_mins_nxt;
      r_hours <= w_hours_nxt;
      r_chg   <= w_mode_rise;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_fire      = 1'b0;

    if (w_mode_rise) begin
      w_mode_nxt = next_mode(r_mode);
    end

    case (r_state)
      INC_IDLE: begin
        if (w_inc_rise) begin
          // A press in RUN, or one coinciding with a mode step, is swallowed
          // until the button is released.
          if (w_mode_rise || (r_mode == MODE_RUN)) begin
            w_state_nxt = INC_LOCKOUT;
          end else begin
            w_fire      = 1'b1;
            w_state_nxt = INC_HOLD;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      INC_HOLD, INC_REPEAT: begin
        if (w_mode_rise) begin
          // Keep a held INC from leaking into the newly selected field.
          w_state_nxt = INC_LOCKOUT;
          w_cnt_nxt   = '0;
        end else if (!w_inc_level) begin
          w_state_nxt = INC_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= w_limit) begin
          w_fire      = 1'b1;
          w_state_nxt = INC_REPEAT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      INC_LOCKOUT: begin
        if (!w_inc_level) begin
          w_state_nxt = INC_IDLE;
        end
      end
      default: begin
        w_state_nxt = INC_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // The pulse targets the field selected by the mode before any advance.
    w_secs_nxt  = w_fire && (r_mode == MODE_SECS);
    w_mins_nxt  = w_fire && (r_mode == MODE_MINS);
    w_hours_nxt = w_fire && (r_mode == MODE_HOURS);
  end

  assign bus.mode      = r_mode;
  assign bus.run_en    = (r_mode == MODE_RUN);
  assign bus.inc_secs  = r_secs;
  assign bus.inc_mins  = r_mins;
  assign bus.inc_hours = r_hours;
  assign bus.mode_chg  = r_chg;

endmodule
`default_nettype wire
